// File: rtl/l2_cache_request_arbiter.sv
// -----------------------------------------------------------------------------
// l2_cache_request_arbiter
//
// First stage of the L2 pipeline. Each cycle, at most one request is picked
// from the L2 bus interface restart path (fills and restarted flushes) or from
// NUM_PORTS core request ports. The winner is registered onto the l2a_* outputs
// that feed l2_cache_tag_stage. The pipeline never stalls, so the grant
// decision is the only flow control.
//
// Priority: restart first, then cores in round-robin order starting at rr_ptr.
// l2bi_stall blocks core grants only.
//
// Optional feature (macro L2_ARB_STARVATION_GUARD_EN):
//   When defined, a counter tracks consecutive restart wins taken while a core
//   was eligible. After STARVE_LIMIT such wins, one restart is refused so an
//   eligible core gets a slot. When undefined, restarts always win and no
//   counter is built.
//
// Packets are carried as flat vectors: REQ_W bits per request packet and
// DATA_W bits per cache line. Core port i occupies
// l2i_request[i*REQ_W +: REQ_W].
//
// Ports:
//   clk                      in   clock
//   reset                    in   synchronous, active-high
//   l2i_request_valid        in   [NUM_PORTS]        per-port request pending
//   l2i_request              in   [NUM_PORTS*REQ_W]  per-port request packets
//   l2_ready                 out  [NUM_PORTS]        one-hot ack, same cycle
//   l2bi_request_valid       in   restart pending
//   l2bi_request             in   [REQ_W]  restart packet
//   l2bi_data_from_memory    in   [DATA_W] fill data
//   l2bi_is_l2_fill          in   restart is a fill
//   l2bi_is_restarted_flush  in   restart is a flush replay
//   l2bi_stall               in   block new core grants
//   l2a_restart_ack          out  restart consumed this cycle (combinational)
//   l2a_request_valid        out  registered grant valid
//   l2a_request              out  [REQ_W]  registered request packet
//   l2a_data_from_memory     out  [DATA_W] registered fill data
//   l2a_is_l2_fill           out  registered fill flag
//   l2a_is_restarted_flush   out  registered flush flag
// -----------------------------------------------------------------------------
module l2_cache_request_arbiter #(
    parameter int NUM_PORTS    = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int REQ_W        = 64,
    parameter int DATA_W       = 512
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic [NUM_PORTS-1:0]       l2i_request_valid,
    input  logic [NUM_PORTS*REQ_W-1:0] l2i_request,
    output logic [NUM_PORTS-1:0]       l2_ready,

    input  logic                       l2bi_request_valid,
    input  logic [REQ_W-1:0]           l2bi_request,
    input  logic [DATA_W-1:0]          l2bi_data_from_memory,
    input  logic                       l2bi_is_l2_fill,
    input  logic                       l2bi_is_restarted_flush,
    input  logic                       l2bi_stall,
    output logic                       l2a_restart_ack,

    output logic                       l2a_request_valid,
    output logic [REQ_W-1:0]           l2a_request,
    output logic [DATA_W-1:0]          l2a_data_from_memory,
    output logic                       l2a_is_l2_fill,
    output logic                       l2a_is_restarted_flush
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Elaboration-time sanity check on the configuration.
    if (NUM_PORTS < 1 || STARVE_LIMIT < 1) begin : g_bad_param
        $error("l2_cache_request_arbiter: NUM_PORTS and STARVE_LIMIT must be >= 1");
    end

    // -------------------------------------------------------------------------
    // Unpack core request packets for indexed selection
    // -------------------------------------------------------------------------
    logic [REQ_W-1:0] port_req [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign port_req[g] = l2i_request[g*REQ_W +: REQ_W];
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic              l2a_request_valid_q,      l2a_request_valid_d;
    logic [REQ_W-1:0]  l2a_request_q,            l2a_request_d;
    logic [DATA_W-1:0] l2a_data_from_memory_q,   l2a_data_from_memory_d;
    logic              l2a_is_l2_fill_q,         l2a_is_l2_fill_d;
    logic              l2a_is_restarted_flush_q, l2a_is_restarted_flush_d;

    // -------------------------------------------------------------------------
    // Round-robin search: first valid port at or above rr_ptr, wrapping.
    // -------------------------------------------------------------------------
    logic             core_found;
    logic [PTR_W-1:0] core_sel;
    logic [PTR_W-1:0] search_idx;

    // NOTE: every signal written in an always_comb gets a default before any
    // conditional assignment; a path that leaves it unassigned infers a latch.
    always_comb begin
        core_found = 1'b0;
        core_sel   = '0;
        search_idx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            search_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_PORTS);
            if (!core_found && l2i_request_valid[search_idx]) begin
                core_found = 1'b1;
                core_sel   = search_idx;
            end
        end
    end

    // A core can only be granted when the miss queue has room.
    logic core_eligible;
    assign core_eligible = core_found && !l2bi_stall;

    // -------------------------------------------------------------------------
    // Starvation guard
    // -------------------------------------------------------------------------
    logic force_core;
    logic restart_grant;
    logic core_grant;

`ifdef L2_ARB_STARVATION_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    // Once the limit is reached, the next eligible core takes the slot from
    // the restart path. The counter can never pass STARVE_LIMIT because the
    // cycle that would push it past is exactly the cycle the core is forced.
    assign force_core = core_eligible && (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (core_grant || !core_eligible) begin
            starve_cnt_d = '0;
        end else if (restart_grant) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign force_core = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Grant decision (combinational, suppressed during reset)
    // -------------------------------------------------------------------------
    assign restart_grant = l2bi_request_valid && !force_core && !reset;
    assign core_grant    = core_eligible && !restart_grant && !reset;

    assign l2a_restart_ack = restart_grant;
    assign l2_ready        = core_grant ? (NUM_PORTS'(1) << core_sel) : '0;

    // -------------------------------------------------------------------------
    // Next-state
    // -------------------------------------------------------------------------
    always_comb begin
        rr_ptr_d                 = rr_ptr_q;
        l2a_request_valid_d      = 1'b0;
        l2a_request_d            = l2a_request_q;
        l2a_data_from_memory_d   = l2a_data_from_memory_q;
        l2a_is_l2_fill_d         = l2a_is_l2_fill_q;
        l2a_is_restarted_flush_d = l2a_is_restarted_flush_q;

        if (restart_grant) begin
            l2a_request_valid_d      = 1'b1;
            l2a_request_d            = l2bi_request;
            l2a_data_from_memory_d   = l2bi_data_from_memory;
            l2a_is_l2_fill_d         = l2bi_is_l2_fill;
            l2a_is_restarted_flush_d = l2bi_is_restarted_flush;
        end else if (core_grant) begin
            // Core requests carry no line data; the data register keeps
            // whatever the last fill left there.
            l2a_request_valid_d      = 1'b1;
            l2a_request_d            = port_req[core_sel];
            l2a_is_l2_fill_d         = 1'b0;
            l2a_is_restarted_flush_d = 1'b0;
            rr_ptr_d = (core_sel == PTR_W'(NUM_PORTS - 1)) ? '0 : core_sel + PTR_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    // NOTE: the wide data register is reset along with the rest so the tag
    // stage never sees X on the output bus after reset; it is a plain
    // register, not a memory array, so the reset costs nothing structural.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q                 <= '0;
            l2a_request_valid_q      <= 1'b0;
            l2a_request_q            <= '0;
            l2a_data_from_memory_q   <= '0;
            l2a_is_l2_fill_q         <= 1'b0;
            l2a_is_restarted_flush_q <= 1'b0;
        end else begin
            rr_ptr_q                 <= rr_ptr_d;
            l2a_request_valid_q      <= l2a_request_valid_d;
            l2a_request_q            <= l2a_request_d;
            l2a_data_from_memory_q   <= l2a_data_from_memory_d;
            l2a_is_l2_fill_q         <= l2a_is_l2_fill_d;
            l2a_is_restarted_flush_q <= l2a_is_restarted_flush_d;
        end
    end

    assign l2a_request_valid      = l2a_request_valid_q;
    assign l2a_request            = l2a_request_q;
    assign l2a_data_from_memory   = l2a_data_from_memory_q;
    assign l2a_is_l2_fill         = l2a_is_l2_fill_q;
    assign l2a_is_restarted_flush = l2a_is_restarted_flush_q;

    // A restart is either a fill or a flush replay, never both.
    a_fill_flush_exclusive : assert property (
        @(posedge clk) disable iff (reset)
        !(l2bi_request_valid && l2bi_is_l2_fill && l2bi_is_restarted_flush)
    );

endmodule
